// File: rtl/drum_hit_judge.sv
// drum_hit_judge: turns PS/2 drum key presses into hits and grades each hit
// against a note timing window (GREAT / GOOD / MISS). It also keeps the
// running score, the current combo and the max combo.
// Optional build macro: DRUM_AUTOPLAY_EN. When it is defined, key edges are
// ignored and every open window is judged GREAT at its centre tick.
module drum_hit_judge #(
   parameter int TICK_DIV  = 50000,
   parameter int WINDOW_MS = 100,
   parameter int GREAT_LO  = 35,
   parameter int GREAT_HI  = 65,
   parameter int GREAT_PTS = 300,
   parameter int GOOD_PTS  = 100,
   parameter int SCORE_W   = 20,
   parameter int COMBO_W   = 10
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic               KEYn1,
   input  logic               KEYn2,
   input  logic               KEYn3,
   input  logic               KEYn4,
   input  logic               note_start,
   input  logic               note_type,
   output logic               judge_valid,
   output logic [1:0]         judge_code,
   output logic [SCORE_W-1:0] score,
   output logic [COMBO_W-1:0] combo,
   output logic [COMBO_W-1:0] max_combo,
   output logic               busy
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int MS_W  = $clog2(WINDOW_MS + 1);

   localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(TICK_DIV - 1);
   localparam logic [MS_W-1:0]    MS_END    = MS_W'(WINDOW_MS);
   localparam logic [MS_W-1:0]    MS_GLO    = MS_W'(GREAT_LO);
   localparam logic [MS_W-1:0]    MS_GHI    = MS_W'(GREAT_HI);
   localparam logic [SCORE_W:0]   PTS_GREAT = (SCORE_W + 1)'(GREAT_PTS);
   localparam logic [SCORE_W:0]   PTS_GOOD  = (SCORE_W + 1)'(GOOD_PTS);

   localparam logic [1:0] C_GREAT = 2'b01;
   localparam logic [1:0] C_GOOD  = 2'b10;
   localparam logic [1:0] C_MISS  = 2'b11;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_OPEN = 2'd1, S_RESULT = 2'd2} state_t;

   state_t             r_state, w_state_nxt;
   logic [3:0]         r_k_s1, r_k_s2, r_k_h;
   logic [3:0]         w_keys, w_fall;
   logic               w_don_hit, w_ka_hit, w_auto;
   logic               w_hit_ok, w_hit_bad, w_in_great;
   logic [PRE_W-1:0]   r_pre;
   logic [MS_W-1:0]    r_ms;
   logic               w_tick;
   logic               r_type, r_pend_vld, r_pend_type;
   logic [1:0]         r_code, w_code_nxt;
   logic               w_open, w_open_type, w_judge, w_pend_wr, w_pend_pop;
   logic [SCORE_W-1:0] r_score;
   logic [COMBO_W-1:0] r_combo, r_max, w_combo_inc;
   logic [SCORE_W:0]   w_pts;

   // Saturating score addition: clamps at the all-ones value of the score.
   function automatic logic [SCORE_W-1:0] sat_add_score(input logic [SCORE_W-1:0] a,
                                                        input logic [SCORE_W:0]   b);
      logic [SCORE_W+1:0] s;
      s = {2'b00, a} + {1'b0, b};
      if (s > {2'b00, {SCORE_W{1'b1}}}) return {SCORE_W{1'b1}};
      return s[SCORE_W-1:0];
   endfunction

   // Saturating combo increment: holds at the all-ones value.
   function automatic logic [COMBO_W-1:0] sat_inc_combo(input logic [COMBO_W-1:0] a);
      if (&a) return a;
      return a + 1'b1;
   endfunction

   assign w_keys = {KEYn4, KEYn3, KEYn2, KEYn1};
   assign w_fall = r_k_h & ~r_k_s2;

`ifdef DRUM_AUTOPLAY_EN
   assign w_don_hit = 1'b0;
   assign w_ka_hit  = 1'b0;
   assign w_auto    = (r_ms == MS_W'((GREAT_LO + GREAT_HI) / 2));
`else
   assign w_don_hit = w_fall[1] | w_fall[2];
   assign w_ka_hit  = w_fall[0] | w_fall[3];
   assign w_auto    = 1'b0;
`endif

   // A simultaneous don+ka press counts as a correct hit for either note type.
   assign w_hit_ok   = r_type ? w_ka_hit  : w_don_hit;
   assign w_hit_bad  = r_type ? w_don_hit : w_ka_hit;
   assign w_in_great = (r_ms >= MS_GLO) && (r_ms <= MS_GHI);
   assign w_tick     = (r_pre == PRE_LAST);

   // Two-flop synchronizer plus history flop per key; released keys read as 1.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_k_s1 <= 4'hF;
         r_k_s2 <= 4'hF;
         r_k_h  <= 4'hF;
      end else begin
         r_k_s1 <= w_keys;
         r_k_s2 <= r_k_s1;
         r_k_h  <= r_k_s2;
      end
   end

   // Millisecond prescaler and in-window tick count; both restart on window open.
   always_ff @(posedge CLOCK_50) begin
      if (reset || w_open) begin
         r_pre <= '0;
         r_ms  <= '0;
      end else begin
         r_pre <= w_tick ? '0 : r_pre + 1'b1;
         if (w_tick && (r_state == S_OPEN) && (r_ms != MS_END)) r_ms <= r_ms + 1'b1;
      end
   end

   // State register.
   always_ff @(posedge CLOCK_50) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state, window open/pending control and judgment outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_open      = 1'b0;
      w_open_type = note_type;
      w_judge     = 1'b0;
      w_code_nxt  = r_code;
      w_pend_wr   = 1'b0;
      w_pend_pop  = 1'b0;
      judge_valid = 1'b0;
      judge_code  = 2'b00;
      case (r_state)
         S_IDLE: begin
            if (note_start) begin
               w_open      = 1'b1;
               w_state_nxt = S_OPEN;
            end
         end
         S_OPEN: begin
            w_pend_wr = note_start;
            if (w_hit_ok) begin
               w_judge     = 1'b1;
               w_code_nxt  = w_in_great ? C_GREAT : C_GOOD;
               w_state_nxt = S_RESULT;
            end else if (w_hit_bad || (r_ms == MS_END)) begin
               w_judge     = 1'b1;
               w_code_nxt  = C_MISS;
               w_state_nxt = S_RESULT;
            end else if (w_auto) begin
               w_judge     = 1'b1;
               w_code_nxt  = C_GREAT;
               w_state_nxt = S_RESULT;
            end
         end
         S_RESULT: begin
            judge_valid = 1'b1;
            judge_code  = r_code;
            if (r_pend_vld) begin
               // Pop the waiting note; a same-cycle note_start refills the slot.
               w_open      = 1'b1;
               w_open_type = r_pend_type;
               w_pend_pop  = 1'b1;
               w_pend_wr   = note_start;
               w_state_nxt = S_OPEN;
            end else if (note_start) begin
               w_open      = 1'b1;
               w_state_nxt = S_OPEN;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Open-note type, latched judgment and the 1-deep pending note slot.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_type      <= 1'b0;
         r_code      <= 2'b00;
         r_pend_vld  <= 1'b0;
         r_pend_type <= 1'b0;
      end else begin
         if (w_open)  r_type <= w_open_type;
         if (w_judge) r_code <= w_code_nxt;
         if (w_pend_wr) begin
            r_pend_vld  <= 1'b1;
            r_pend_type <= note_type;
         end else if (w_pend_pop) begin
            r_pend_vld  <= 1'b0;
         end
      end
   end

   assign w_combo_inc = sat_inc_combo(r_combo);
   assign w_pts       = (r_code == C_GREAT) ? PTS_GREAT : PTS_GOOD;

   // Score, combo and max combo update during the RESULT cycle.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_score <= '0;
         r_combo <= '0;
         r_max   <= '0;
      end else if (r_state == S_RESULT) begin
         if (r_code == C_MISS) begin
            r_combo <= '0;
         end else begin
            r_score <= sat_add_score(r_score, w_pts);
            r_combo <= w_combo_inc;
            if (w_combo_inc > r_max) r_max <= w_combo_inc;
         end
      end
   end

   assign score     = r_score;
   assign combo     = r_combo;
   assign max_combo = r_max;
   assign busy      = (r_state != S_IDLE) | r_pend_vld;

endmodule
